// File: rtl/usb_tx_pkg.sv
// Shared types and field lengths for the USB transmit sequencer.
// Contents:
//   state_e     - sequencer states (IDLE .. EOP)
//   pkt_type_e  - request packet type encoding
//   *_BITS      - field lengths in USB bit periods
//   STUFF_RUN   - consecutive ones that force an inserted stuff bit
package usb_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        PID,
        DATA,
        TOKEN,
        CRC16,
        CRC5,
        EOP
    } state_e;

    typedef enum logic [1:0] {
        PKT_HANDSHAKE = 2'b00,
        PKT_DATA      = 2'b01,
        PKT_TOKEN     = 2'b10,
        PKT_RESERVED  = 2'b11
    } pkt_type_e;

    localparam int SYNC_BITS    = 8;
    localparam int PID_BITS     = 8;
    localparam int TOKEN_BITS   = 11;
    localparam int CRC16_BITS   = 16;
    localparam int CRC5_BITS    = 5;
    localparam int EOP_SE0_BITS = 2;
    localparam int STUFF_RUN    = 6;

endpackage

// File: rtl/usb_bit_timer.sv
// USB bit-period timer.
// Ports:
//   clk      in  system clock
//   rst      in  synchronous active-high reset
//   restart  in  hold the period counter at its first cycle
//   bit_end  out high in the last cycle of every bit period
module usb_bit_timer #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_end
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign bit_end = (cnt_q == CW'(CLKS_PER_BIT - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || bit_end) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/usb_tx_sequencer.sv
// USB transmit sequencer: accepts one packet request and steps the field shift
// register and NRZI encoder through SYNC, PID, payload/token, CRC and EOP,
// inserting stuff bits after every run of STUFF_RUN transmitted ones.
// Optional feature macro: USB_TX_TOKEN_EN (token packets with CRC5). When it is
// undefined, token requests are rejected and the TOKEN/CRC5 paths are not built.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   start, pkt_type, byte_cnt     packet request (sampled only in IDLE)
//   d_orig                        current field bit, used for stuffing
//   sync/pid/data/crc_load_enable one-cycle field load strobes
//   shift_enable                  one-cycle advance of the active field
//   stuff, eop, idle              line-level controls for the encoder
//   busy, done, err               status to host logic
module usb_tx_sequencer
    import usb_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int MAX_BYTES    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] pkt_type,
    input  logic [3:0] byte_cnt,
    input  logic       d_orig,
    output logic       sync_load_enable,
    output logic       pid_load_enable,
    output logic       data_load_enable,
    output logic       crc_load_enable,
    output logic       shift_enable,
    output logic       stuff,
    output logic       eop,
    output logic       idle,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int DATA_MAX_BITS = MAX_BYTES * 8;
    localparam int BCW = ($clog2(DATA_MAX_BITS + 1) > 5) ? $clog2(DATA_MAX_BITS + 1) : 5;

    state_e          state_q, state_d, next_field;
    pkt_type_e       pkt_q, pkt_d;
    logic [BCW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [BCW-1:0]  data_bits_q, data_bits_d;
    logic [BCW-1:0]  field_last;
    logic [2:0]      ones_q, ones_d;
    logic            stuff_q, stuff_d;
    logic            first_q, first_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            bit_end;
    logic            last_bit;
    logic            counted;
    logic            in_field;
    logic            req_valid;

    // Timer is held at cycle 0 while idle so the first SYNC period is aligned
    // to the accept edge; after that fields follow back to back.
    usb_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
        .clk     (clk),
        .rst     (rst),
        .restart (state_q == IDLE),
        .bit_end (bit_end)
    );

    always_comb begin
        req_valid = (int'(byte_cnt) <= MAX_BYTES);
        case (pkt_type)
            2'b11: req_valid = 1'b0;
`ifndef USB_TX_TOKEN_EN
            2'b10: req_valid = 1'b0;
`endif
            default: ;
        endcase
    end

    // Index of the last bit period of the current state. For EOP this is the
    // final J bit following the SE0 bits.
    always_comb begin
        field_last = '0;
        case (state_q)
            SYNC:    field_last = BCW'(SYNC_BITS - 1);
            PID:     field_last = BCW'(PID_BITS - 1);
            DATA:    field_last = data_bits_q - BCW'(1);
            TOKEN:   field_last = BCW'(TOKEN_BITS - 1);
            CRC16:   field_last = BCW'(CRC16_BITS - 1);
            CRC5:    field_last = BCW'(CRC5_BITS - 1);
            EOP:     field_last = BCW'(EOP_SE0_BITS);
            default: field_last = '0;
        endcase
    end

    always_comb begin
        next_field = IDLE;
        case (state_q)
            SYNC: next_field = PID;
            PID: begin
                case (pkt_q)
                    PKT_DATA:  next_field = (data_bits_q != '0) ? DATA : CRC16;
`ifdef USB_TX_TOKEN_EN
                    PKT_TOKEN: next_field = TOKEN;
`endif
                    default:   next_field = EOP;
                endcase
            end
            DATA:  next_field = CRC16;
`ifdef USB_TX_TOKEN_EN
            TOKEN: next_field = CRC5;
            CRC5:  next_field = EOP;
`endif
            CRC16: next_field = EOP;
            default: next_field = IDLE;
        endcase
    end

    assign last_bit = (bit_cnt_q == field_last);
    // SYNC is a fixed pattern and never contributes to a ones run.
    assign counted  = state_q inside {PID, DATA, TOKEN, CRC16, CRC5};
    assign in_field = counted || (state_q == SYNC);

    always_comb begin
        state_d     = state_q;
        pkt_d       = pkt_q;
        bit_cnt_d   = bit_cnt_q;
        data_bits_d = data_bits_q;
        ones_d      = ones_q;
        stuff_d     = stuff_q;
        first_d     = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        if (state_q == IDLE) begin
            bit_cnt_d = '0;
            ones_d    = '0;
            stuff_d   = 1'b0;
            if (start) begin
                if (req_valid) begin
                    state_d     = SYNC;
                    first_d     = 1'b1;
                    pkt_d       = pkt_type_e'(pkt_type);
                    data_bits_d = BCW'({byte_cnt, 3'b000});
                end else begin
                    err_d = 1'b1;
                end
            end
        end else if (bit_end) begin
            if (stuff_q) begin
                // Inserted zero: no field bit consumed, just resume.
                stuff_d = 1'b0;
            end else begin
                if (counted) begin
                    if (!d_orig) begin
                        ones_d = '0;
                    end else if (ones_q == 3'(STUFF_RUN - 1)) begin
                        ones_d  = '0;
                        stuff_d = 1'b1;
                    end else begin
                        ones_d = ones_q + 3'd1;
                    end
                end
                if (last_bit) begin
                    bit_cnt_d = '0;
                    state_d   = next_field;
                    first_d   = (state_q != EOP);
                    done_d    = (state_q == EOP);
                end else begin
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pkt_q       <= PKT_HANDSHAKE;
            bit_cnt_q   <= '0;
            data_bits_q <= '0;
            ones_q      <= '0;
            stuff_q     <= 1'b0;
            first_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pkt_q       <= pkt_d;
            bit_cnt_q   <= bit_cnt_d;
            data_bits_q <= data_bits_d;
            ones_q      <= ones_d;
            stuff_q     <= stuff_d;
            first_q     <= first_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign sync_load_enable = first_q && (state_q == SYNC);
    assign pid_load_enable  = first_q && (state_q == PID);
    assign data_load_enable = first_q && ((state_q == DATA) || (state_q == TOKEN));
    assign crc_load_enable  = first_q && ((state_q == CRC16) || (state_q == CRC5));
    assign shift_enable     = bit_end && !stuff_q && in_field && !last_bit;
    assign stuff            = stuff_q;
    assign eop              = (state_q == EOP) && !stuff_q && (bit_cnt_q < BCW'(EOP_SE0_BITS));
    assign idle             = (state_q == IDLE) ||
                              ((state_q == EOP) && !stuff_q && (bit_cnt_q == BCW'(EOP_SE0_BITS)));
    assign busy             = (state_q != IDLE);
    assign done             = done_q;
    assign err              = err_q;

endmodule

// File: tb/tb_usb_tx_sequencer.sv
module tb_usb_tx_sequencer;

    localparam int CPB  = 8;
    localparam int MAXC = 2048;

    // Bit positions in the packed observation vector.
    localparam int B_SYNC  = 10;
    localparam int B_PID   = 9;
    localparam int B_DATA  = 8;
    localparam int B_CRC   = 7;
    localparam int B_SHIFT = 6;
    localparam int B_STUFF = 5;
    localparam int B_EOP   = 4;
    localparam int B_IDLE  = 3;
    localparam int B_BUSY  = 2;
    localparam int B_DONE  = 1;
    localparam int B_ERR   = 0;

    localparam logic [10:0] IDLE_V = 11'b000_0000_1000;
    localparam logic [10:0] DONE_V = 11'b000_0000_1010;
    localparam logic [10:0] ERR_V  = 11'b000_0000_1001;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] pkt_type;
    logic [3:0] byte_cnt;
    logic       d_orig;
    logic       sync_load_enable, pid_load_enable, data_load_enable, crc_load_enable;
    logic       shift_enable, stuff, eop, idle, busy, done, err;
    logic [10:0] vec;

    int n_checks = 0;
    int n_fail   = 0;

    logic [10:0] exp_v [MAXC];
    logic        exp_d [MAXC];
    logic [10:0] obs   [MAXC];
    int          exp_len;

    always #5 clk = ~clk;

    usb_tx_sequencer #(.CLKS_PER_BIT(CPB), .MAX_BYTES(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .pkt_type         (pkt_type),
        .byte_cnt         (byte_cnt),
        .d_orig           (d_orig),
        .sync_load_enable (sync_load_enable),
        .pid_load_enable  (pid_load_enable),
        .data_load_enable (data_load_enable),
        .crc_load_enable  (crc_load_enable),
        .shift_enable     (shift_enable),
        .stuff            (stuff),
        .eop              (eop),
        .idle             (idle),
        .busy             (busy),
        .done             (done),
        .err              (err)
    );

    assign vec = {sync_load_enable, pid_load_enable, data_load_enable, crc_load_enable,
                  shift_enable, stuff, eop, idle, busy, done, err};

    // ---------------- reference model: period-level schedule ----------------
    task automatic add_period(input int load_bit, input logic st, input logic sh,
                              input logic e, input logic j, input logic d);
        logic [10:0] v;
        for (int c = 0; c < CPB; c++) begin
            v = '0;
            v[B_BUSY]  = 1'b1;
            if (c == 0 && load_bit >= 0) v[load_bit] = 1'b1;
            if (c == CPB - 1 && sh) v[B_SHIFT] = 1'b1;
            v[B_STUFF] = st;
            v[B_EOP]   = e;
            v[B_IDLE]  = j;
            exp_v[exp_len] = v;
            exp_d[exp_len] = d;
            exp_len++;
        end
    endtask

    // dmode: 0 all zeros, 1 all ones, 2 random (biased to ones)
    task automatic build_expected(input logic [1:0] pt, input int nbytes, input int dmode);
        int   flen[$];
        int   fbit[$];
        int   ones, ld;
        logic pend, d;
        exp_len = 0;
        flen.push_back(8); fbit.push_back(B_SYNC);
        flen.push_back(8); fbit.push_back(B_PID);
        if (pt == 2'b01) begin
            if (nbytes > 0) begin flen.push_back(8 * nbytes); fbit.push_back(B_DATA); end
            flen.push_back(16); fbit.push_back(B_CRC);
        end else if (pt == 2'b10) begin
            flen.push_back(11); fbit.push_back(B_DATA);
            flen.push_back(5);  fbit.push_back(B_CRC);
        end
        ones = 0;
        pend = 1'b0;
        foreach (flen[f]) begin
            ld = fbit[f];
            for (int b = 0; b < flen[f]; b++) begin
                if (pend) begin
                    add_period(ld, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                    ld = -1;
                    pend = 1'b0;
                end
                case (dmode)
                    0:       d = 1'b0;
                    1:       d = 1'b1;
                    default: d = (($urandom % 4) != 0);
                endcase
                add_period(ld, 1'b0, (b != flen[f] - 1), 1'b0, 1'b0, d);
                ld = -1;
                if (f != 0) begin
                    ones = d ? ones + 1 : 0;
                    if (ones == 6) begin pend = 1'b1; ones = 0; end
                end
            end
        end
        if (pend) add_period(-1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add_period(-1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        add_period(-1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        add_period(-1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        exp_v[exp_len] = DONE_V; exp_d[exp_len] = 1'b0; exp_len++;
        exp_v[exp_len] = IDLE_V; exp_d[exp_len] = 1'b0; exp_len++;
    endtask

    // Drives one request at cycle T and records outputs of cycles T+1.. into obs[].
    task automatic run_packet(input logic [1:0] pt, input int nb, input int busy_start);
        @(posedge clk); #1;
        start = 1'b1; pkt_type = pt; byte_cnt = 4'(nb);
        for (int i = 0; i < exp_len; i++) begin
            @(posedge clk); #1;
            if (busy_start != 0 && i < exp_len - 2) begin
                start    = $urandom_range(0, 1) == 1;
                pkt_type = 2'($urandom_range(0, 3));
                byte_cnt = 4'($urandom_range(0, 15));
            end else begin
                start = 1'b0;
            end
            d_orig = exp_d[i];
            @(negedge clk);
            obs[i] = vec;
        end
        start = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    function automatic int count_bit(input int b);
        int n = 0;
        for (int i = 0; i < exp_len; i++) if (obs[i][b]) n++;
        return n;
    endfunction

    function automatic int first_at(input int b);
        for (int i = 0; i < exp_len; i++) if (obs[i][b]) return i;
        return -1;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; start = 1'b0; pkt_type = 2'b00; byte_cnt = 4'd0; d_orig = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (vec !== IDLE_V) begin
            n_fail++;
            $display("FAIL reset_in: got %b expected %b", vec, IDLE_V);
        end
        @(posedge clk); #1; rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (vec !== IDLE_V) begin
            n_fail++;
            $display("FAIL reset_out: got %b expected %b", vec, IDLE_V);
        end
        $display("reset: outputs %b", vec);
    endtask

    task automatic test_handshake();
        logic bad = 1'b0;
        build_expected(2'b00, 0, 0);
        run_packet(2'b00, 0, 0);
        n_checks++;
        for (int i = 0; i < exp_len; i++)
            if (!bad && obs[i] !== exp_v[i]) begin
                bad = 1'b1; n_fail++;
                $display("FAIL handshake_trace at T+%0d: got %b expected %b", i + 1, obs[i], exp_v[i]);
            end
        n_checks++;
        if (first_at(B_SYNC) !== 0) begin n_fail++; $display("FAIL hs_sync_load: got T+%0d expected T+1", first_at(B_SYNC) + 1); end
        n_checks++;
        if (first_at(B_PID) !== 64) begin n_fail++; $display("FAIL hs_pid_load: got T+%0d expected T+65", first_at(B_PID) + 1); end
        n_checks++;
        if (first_at(B_DONE) !== 19 * 8) begin n_fail++; $display("FAIL hs_done: got T+%0d expected T+%0d", first_at(B_DONE) + 1, 19 * 8 + 1); end
        n_checks++;
        if (count_bit(B_SHIFT) !== 14) begin n_fail++; $display("FAIL hs_shifts: got %0d expected 14", count_bit(B_SHIFT)); end
        n_checks++;
        if (count_bit(B_EOP) !== 16) begin n_fail++; $display("FAIL hs_eop_cycles: got %0d expected 16", count_bit(B_EOP)); end
        $display("handshake: done at T+%0d shifts=%0d", first_at(B_DONE) + 1, count_bit(B_SHIFT));
    endtask

    task automatic test_data();
        logic bad = 1'b0;
        build_expected(2'b01, 2, 0);
        run_packet(2'b01, 2, 0);
        n_checks++;
        for (int i = 0; i < exp_len; i++)
            if (!bad && obs[i] !== exp_v[i]) begin
                bad = 1'b1; n_fail++;
                $display("FAIL data2_trace at T+%0d: got %b expected %b", i + 1, obs[i], exp_v[i]);
            end
        n_checks++;
        if (first_at(B_DATA) - first_at(B_PID) !== 64) begin n_fail++; $display("FAIL data2_data_load: got %0d cycles after pid expected 64", first_at(B_DATA) - first_at(B_PID)); end
        n_checks++;
        if (first_at(B_CRC) - first_at(B_DATA) !== 128) begin n_fail++; $display("FAIL data2_crc_load: got %0d cycles after data expected 128", first_at(B_CRC) - first_at(B_DATA)); end
        n_checks++;
        if (count_bit(B_SHIFT) !== 44) begin n_fail++; $display("FAIL data2_shifts: got %0d expected 44", count_bit(B_SHIFT)); end
        n_checks++;
        if (first_at(B_DONE) !== 51 * 8) begin n_fail++; $display("FAIL data2_done: got T+%0d expected T+%0d", first_at(B_DONE) + 1, 51 * 8 + 1); end
        $display("data2: done at T+%0d shifts=%0d", first_at(B_DONE) + 1, count_bit(B_SHIFT));
    endtask

    task automatic test_stuffing();
        logic bad = 1'b0;
        int   overlap = 0;
        build_expected(2'b01, 0, 1);
        run_packet(2'b01, 0, 0);
        n_checks++;
        for (int i = 0; i < exp_len; i++)
            if (!bad && obs[i] !== exp_v[i]) begin
                bad = 1'b1; n_fail++;
                $display("FAIL stuff_trace at T+%0d: got %b expected %b", i + 1, obs[i], exp_v[i]);
            end
        for (int i = 0; i < exp_len; i++) if (obs[i][B_STUFF] && obs[i][B_SHIFT]) overlap++;
        n_checks++;
        if (count_bit(B_STUFF) !== 4 * CPB) begin n_fail++; $display("FAIL stuff_cycles: got %0d expected %0d", count_bit(B_STUFF), 4 * CPB); end
        n_checks++;
        if (overlap !== 0) begin n_fail++; $display("FAIL stuff_shift_overlap: got %0d expected 0", overlap); end
        n_checks++;
        if (count_bit(B_SHIFT) !== 29) begin n_fail++; $display("FAIL stuff_shifts: got %0d expected 29", count_bit(B_SHIFT)); end
        n_checks++;
        if (first_at(B_DONE) !== 39 * 8) begin n_fail++; $display("FAIL stuff_done: got T+%0d expected T+%0d", first_at(B_DONE) + 1, 39 * 8 + 1); end
        $display("stuffing: stuff cycles=%0d done at T+%0d", count_bit(B_STUFF), first_at(B_DONE) + 1);
    endtask

    task automatic test_reject();
        logic [1:0] pts [4] = '{2'b11, 2'b01, 2'b00, 2'b10};
        int         nbs [4] = '{0, 9, 15, 0};
        int         ncase;
        logic [10:0] v1, v2;
`ifdef USB_TX_TOKEN_EN
        ncase = 3;
`else
        ncase = 4;
`endif
        for (int k = 0; k < ncase; k++) begin
            @(posedge clk); #1;
            start = 1'b1; pkt_type = pts[k]; byte_cnt = 4'(nbs[k]);
            @(posedge clk); #1; start = 1'b0;
            @(negedge clk); v1 = vec;
            @(negedge clk); v2 = vec;
            n_checks++;
            if (v1 !== ERR_V) begin n_fail++; $display("FAIL reject_err type=%b bytes=%0d: got %b expected %b", pts[k], nbs[k], v1, ERR_V); end
            n_checks++;
            if (v2 !== IDLE_V) begin n_fail++; $display("FAIL reject_after type=%b bytes=%0d: got %b expected %b", pts[k], nbs[k], v2, IDLE_V); end
            $display("reject: type=%b bytes=%0d -> %b then %b", pts[k], nbs[k], v1, v2);
        end
    endtask

    task automatic test_reset_mid();
        int   dones = 0;
        logic was_busy;
        build_expected(2'b01, 4, 2);
        @(posedge clk); #1;
        start = 1'b1; pkt_type = 2'b01; byte_cnt = 4'd4;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1; start = 1'b0; d_orig = exp_d[i];
        end
        @(negedge clk); was_busy = busy;
        #1; rst = 1'b1;
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (was_busy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_busy_before: got %b expected 1", was_busy); end
        n_checks++;
        if (vec !== IDLE_V) begin n_fail++; $display("FAIL rst_mid_outputs: got %b expected %b", vec, IDLE_V); end
        @(posedge clk); #1; rst = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        n_checks++;
        if (dones !== 0) begin n_fail++; $display("FAIL rst_mid_no_done: got %0d active cycles expected 0", dones); end
        $display("reset mid-data: outputs after rst %b", IDLE_V);
    endtask

    task automatic test_busy_start();
        logic bad = 1'b0;
        build_expected(2'b00, 0, 2);
        run_packet(2'b00, 0, 1);
        n_checks++;
        for (int i = 0; i < exp_len; i++)
            if (!bad && obs[i] !== exp_v[i]) begin
                bad = 1'b1; n_fail++;
                $display("FAIL busy_start_trace at T+%0d: got %b expected %b", i + 1, obs[i], exp_v[i]);
            end
        $display("start while busy: trace length %0d checked", exp_len);
    endtask

`ifdef USB_TX_TOKEN_EN
    task automatic test_token();
        logic bad = 1'b0;
        build_expected(2'b10, 0, 0);
        run_packet(2'b10, 0, 0);
        n_checks++;
        for (int i = 0; i < exp_len; i++)
            if (!bad && obs[i] !== exp_v[i]) begin
                bad = 1'b1; n_fail++;
                $display("FAIL token_trace at T+%0d: got %b expected %b", i + 1, obs[i], exp_v[i]);
            end
        n_checks++;
        if (first_at(B_CRC) - first_at(B_DATA) !== 88) begin n_fail++; $display("FAIL token_crc_load: got %0d cycles after data expected 88", first_at(B_CRC) - first_at(B_DATA)); end
        n_checks++;
        if (first_at(B_DONE) !== 35 * 8) begin n_fail++; $display("FAIL token_done: got T+%0d expected T+%0d", first_at(B_DONE) + 1, 35 * 8 + 1); end
        $display("token: done at T+%0d", first_at(B_DONE) + 1);
    endtask
`endif

    task automatic test_random();
        logic [1:0] pt;
        int         nb;
        for (int k = 0; k < 8; k++) begin
            logic bad = 1'b0;
`ifdef USB_TX_TOKEN_EN
            pt = 2'($urandom_range(0, 2));
`else
            pt = 2'($urandom_range(0, 1));
`endif
            nb = (pt == 2'b01) ? $urandom_range(0, 8) : 0;
            build_expected(pt, nb, 2);
            run_packet(pt, nb, 0);
            n_checks++;
            for (int i = 0; i < exp_len; i++)
                if (!bad && obs[i] !== exp_v[i]) begin
                    bad = 1'b1; n_fail++;
                    $display("FAIL random_trace pkt %0d at T+%0d: got %b expected %b", k, i + 1, obs[i], exp_v[i]);
                end
            $display("random pkt %0d: type=%b bytes=%0d cycles=%0d", k, pt, nb, exp_len);
        end
    endtask

    initial begin
        test_reset();
        test_handshake();
        test_data();
        test_stuffing();
        test_reject();
        test_reset_mid();
        test_busy_start();
`ifdef USB_TX_TOKEN_EN
        test_token();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
